// File: rtl/parking_gate_ctrl.sv
// Single-lane barrier controller: round-robin entry/exit arbitration, raise/hold/lower
// motor sequencing with hold timeout, and a saturating occupancy counter.
module parking_gate_ctrl #(
    parameter int CAPACITY      = 16,
    parameter int CNT_W         = 5,
    parameter int TRAVEL_CYCLES = 8,
    parameter int HOLD_TIMEOUT  = 64,
    parameter int TMR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_in,
    input  logic             req_out,
    input  logic             entrada,
    input  logic             salida,
    output logic             motor_up,
    output logic             motor_down,
    output logic             gate_open,
    output logic             grant_in,
    output logic             grant_out,
    output logic             busy,
    output logic             timeout_evt,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    typedef enum logic [1:0] {IDLE, RAISE, HOLD, LOWER} state_t;

    localparam logic [TMR_W-1:0] TRAVEL_LAST = TMR_W'(TRAVEL_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST   = TMR_W'(HOLD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CAP_C       = CNT_W'(CAPACITY);

    state_t             state_q, state_d;
    logic               dir_q, dir_d;
    logic               last_dir_q, last_dir_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               tout_q, tout_d;
    logic               in_ok, match;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            dir_q      <= 1'b0;
            last_dir_q <= 1'b0;
            tmr_q      <= '0;
            count_q    <= '0;
            tout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            last_dir_q <= last_dir_d;
            tmr_q      <= tmr_d;
            count_q    <= count_d;
            tout_q     <= tout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        last_dir_d = last_dir_q;
        tmr_d      = tmr_q;
        tout_d     = 1'b0;
        in_ok      = req_in & ~full;
        match      = dir_q ? entrada : salida;
        case (state_q)
            IDLE: begin
                if (in_ok || req_out) begin
                    // A tie alternates against whichever side was served last.
                    dir_d      = (in_ok && req_out) ? ~last_dir_q : in_ok;
                    last_dir_d = dir_d;
                    state_d    = RAISE;
                    tmr_d      = '0;
                end
            end
            RAISE: begin
                if (tmr_q == TRAVEL_LAST) begin
                    state_d = HOLD;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            HOLD: begin
                if (match) begin
                    state_d = LOWER;
                    tmr_d   = '0;
                end else if (tmr_q == HOLD_LAST) begin
                    state_d = LOWER;
                    tmr_d   = '0;
                    tout_d  = 1'b1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            LOWER: begin
                if (tmr_q == TRAVEL_LAST) begin
                    state_d = IDLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tmr_d   = '0;
            end
        endcase
    end

    // Sensor pulses are ground truth, so occupancy tracks them in every state.
    always_comb begin
        count_d = count_q;
        if (entrada && !salida && count_q != CAP_C) begin
            count_d = count_q + CNT_W'(1);
        end else if (salida && !entrada && count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    assign motor_up    = (state_q == RAISE);
    assign motor_down  = (state_q == LOWER);
    assign gate_open   = (state_q == HOLD);
    assign busy        = (state_q != IDLE);
    assign grant_in    = busy & dir_q;
    assign grant_out   = busy & ~dir_q;
    assign timeout_evt = tout_q;
    assign count       = count_q;
    assign full        = (count_q == CAP_C);
    assign empty       = (count_q == '0);
endmodule
